// File: rtl/pattern_source.sv
// pattern_source: test-pattern pixel source for the VGA timing driver.
//
// The driver requests a pixel at (p_xpos, p_ypos). The registered RGB-888
// answer appears on pdata_rgb one clock later, which matches the driver's
// one-cycle request lead. Five patterns are available: colour bars,
// checkerboard, grey ramp, vertical gradient and a bouncing box. Patterns
// can be picked manually or cycled automatically, one pattern every
// FRAMES_PER_PATTERN frames.
//
// Ports:
//   pclk        pixel clock, all logic on the rising edge
//   arst        asynchronous reset, active-high
//   p_xpos      requested pixel column, 0-based
//   p_ypos      requested pixel line, offset by Y_OFFSET
//   video_vs    vertical sync from the driver, active-low
//   auto_en     1 = auto-cycle patterns, 0 = use pattern_sel
//   pattern_sel manual pattern select
//   pdata_rgb   registered pixel data {R,G,B}
//   pattern_cur pattern currently displayed
//
// Optional feature macro: PATTERN_BORDER_EN. When it is defined, a
// 1-pixel white border overrides every pattern on the edge of the
// active area.

module pattern_source #(
  parameter int H_DISP             = 1280,
  parameter int V_DISP             = 720,
  parameter int Y_OFFSET           = 1,
  parameter int BOX_SIZE           = 64,
  parameter int BOX_STEP           = 4,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic        pclk,
  input  logic        arst,
  input  logic [15:0] p_xpos,
  input  logic [15:0] p_ypos,
  input  logic        video_vs,
  input  logic        auto_en,
  input  logic [2:0]  pattern_sel,
  output logic [23:0] pdata_rgb,
  output logic [2:0]  pattern_cur
);

  localparam int          BAR_W      = H_DISP / 8;
  localparam logic [15:0] H_LIM      = 16'(H_DISP);
  localparam logic [15:0] V_LIM      = 16'(V_DISP);
  localparam logic [15:0] Y_OFF      = 16'(Y_OFFSET);
  localparam logic [16:0] BOX_SZ     = 17'(BOX_SIZE);
  localparam logic [16:0] STEP_W     = 17'(BOX_STEP);
  localparam logic [15:0] STEP_N     = 16'(BOX_STEP);
  localparam logic [15:0] BX_MAX     = 16'(H_DISP - BOX_SIZE);
  localparam logic [15:0] BY_MAX     = 16'(V_DISP - BOX_SIZE);
  localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_PATTERN - 1);

  typedef enum logic {MANUAL, AUTO} mode_t;

  mode_t       mode_q, mode_d;
  logic        vs_q, vs_d;
  logic [23:0] pdata_rgb_q, pdata_rgb_d;
  logic [2:0]  pattern_cur_q, pattern_cur_d;
  logic [15:0] count_q, count_d;
  logic [15:0] bx_q, bx_d, by_q, by_d;
  logic        bx_fwd_q, bx_fwd_d, by_fwd_q, by_fwd_d;

  logic        tick;
  logic [15:0] y;
  logic        in_range;
  logic [2:0]  bar;
  logic [7:0]  gray;
  logic [7:0]  vgrad;
  logic        in_box;
  logic [23:0] pattern_rgb;
  logic [16:0] x_step, y_step;

  // One axis of the bouncing box. Returns {direction, position}; the box
  // clamps to the wall and reverses instead of overshooting it.
  function automatic logic [16:0] axis_next(input logic [15:0] pos,
                                            input logic        fwd,
                                            input logic [15:0] max_pos);
    logic [16:0] r;
    if (fwd) begin
      if (({1'b0, pos} + STEP_W) >= {1'b0, max_pos}) r = {1'b0, max_pos};
      else                                           r = {1'b1, pos + STEP_N};
    end else begin
      if (pos <= STEP_N) r = {1'b1, 16'd0};
      else               r = {1'b0, pos - STEP_N};
    end
    return r;
  endfunction

  assign tick = vs_q & ~video_vs;

  // Pixel generation for the coordinates requested this cycle. A line
  // above Y_OFFSET wraps y to a large value and lands out of range.
  always_comb begin
    y        = p_ypos - Y_OFF;
    in_range = (p_ypos >= Y_OFF) && (y < V_LIM) && (p_xpos < H_LIM);

    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (p_xpos >= 16'(k * BAR_W)) bar = 3'(k);
    end

    gray  = (p_xpos[15:10] != 6'd0) ? 8'hFF : p_xpos[9:2];
    vgrad = (y[15:10] != 6'd0)      ? 8'hFF : y[9:2];

    in_box = ({1'b0, p_xpos} >= {1'b0, bx_q}) &&
             ({1'b0, p_xpos} <  ({1'b0, bx_q} + BOX_SZ)) &&
             ({1'b0, y}      >= {1'b0, by_q}) &&
             ({1'b0, y}      <  ({1'b0, by_q} + BOX_SZ));

    pattern_rgb = 24'h000000;
    case (pattern_cur_q)
      3'd0: begin
        case (bar)
          3'd0:    pattern_rgb = 24'hFFFFFF;
          3'd1:    pattern_rgb = 24'hFFFF00;
          3'd2:    pattern_rgb = 24'h00FFFF;
          3'd3:    pattern_rgb = 24'h00FF00;
          3'd4:    pattern_rgb = 24'hFF00FF;
          3'd5:    pattern_rgb = 24'hFF0000;
          3'd6:    pattern_rgb = 24'h0000FF;
          default: pattern_rgb = 24'h000000;
        endcase
      end
      3'd1:    pattern_rgb = (p_xpos[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
      3'd2:    pattern_rgb = {gray, gray, gray};
      3'd3:    pattern_rgb = {8'h00, vgrad, 8'hFF - vgrad};
      3'd4:    pattern_rgb = in_box ? 24'hFFFFFF : 24'h000040;
      default: pattern_rgb = 24'h000000;
    endcase

`ifdef PATTERN_BORDER_EN
    if ((p_xpos == 16'd0) || (p_xpos == H_LIM - 16'd1) ||
        (y == 16'd0) || (y == V_LIM - 16'd1)) begin
      pattern_rgb = 24'hFFFFFF;
    end
`endif

    pdata_rgb_d = in_range ? pattern_rgb : 24'h000000;
  end

  // Frame-level state: box motion and pattern selection. Everything holds
  // except on the vsync falling-edge tick, so nothing changes mid-frame.
  always_comb begin
    vs_d          = video_vs;
    mode_d        = mode_q;
    pattern_cur_d = pattern_cur_q;
    count_d       = count_q;
    bx_d          = bx_q;
    by_d          = by_q;
    bx_fwd_d      = bx_fwd_q;
    by_fwd_d      = by_fwd_q;
    x_step        = axis_next(bx_q, bx_fwd_q, BX_MAX);
    y_step        = axis_next(by_q, by_fwd_q, BY_MAX);

    if (tick) begin
      {bx_fwd_d, bx_d} = x_step;
      {by_fwd_d, by_d} = y_step;

      if (!auto_en) begin
        mode_d        = MANUAL;
        pattern_cur_d = pattern_sel;
        count_d       = 16'd0;
      end else if (mode_q == MANUAL) begin
        // Entering auto keeps the current pattern unless it is not part
        // of the 0..4 cycle.
        mode_d  = AUTO;
        count_d = 16'd0;
        if (pattern_cur_q > 3'd4) pattern_cur_d = 3'd0;
      end else if (count_q == FRAME_LAST) begin
        count_d       = 16'd0;
        pattern_cur_d = (pattern_cur_q >= 3'd4) ? 3'd0 : pattern_cur_q + 3'd1;
      end else begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pclk or posedge arst) begin
    if (arst) begin
      mode_q        <= MANUAL;
      vs_q          <= 1'b1;
      pdata_rgb_q   <= 24'h000000;
      pattern_cur_q <= 3'd0;
      count_q       <= 16'd0;
      bx_q          <= 16'd0;
      by_q          <= 16'd0;
      bx_fwd_q      <= 1'b1;
      by_fwd_q      <= 1'b1;
    end else begin
      mode_q        <= mode_d;
      vs_q          <= vs_d;
      pdata_rgb_q   <= pdata_rgb_d;
      pattern_cur_q <= pattern_cur_d;
      count_q       <= count_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      bx_fwd_q      <= bx_fwd_d;
      by_fwd_q      <= by_fwd_d;
    end
  end

  assign pdata_rgb   = pdata_rgb_q;
  assign pattern_cur = pattern_cur_q;

endmodule

// File: tb/tb_pattern_source.sv
// Testbench for pattern_source. Pixel requests and frame ticks are checked
// against a behavioural model of the pattern rules and frame-level state.

module tb_pattern_source;

  localparam int H_DISP   = 1280;
  localparam int V_DISP   = 720;
  localparam int Y_OFFSET = 1;
  localparam int BOX_SIZE = 64;
  localparam int BOX_STEP = 4;
  localparam int FPP      = 3;

  logic        pclk = 1'b0;
  logic        arst;
  logic [15:0] p_xpos;
  logic [15:0] p_ypos;
  logic        video_vs;
  logic        auto_en;
  logic [2:0]  pattern_sel;
  logic [23:0] pdata_rgb;
  logic [2:0]  pattern_cur;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_pat, m_bx, m_by, m_cnt;
  bit m_dx, m_dy, m_auto;

  pattern_source #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .Y_OFFSET(Y_OFFSET),
    .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP), .FRAMES_PER_PATTERN(FPP)
  ) dut (
    .pclk(pclk), .arst(arst), .p_xpos(p_xpos), .p_ypos(p_ypos),
    .video_vs(video_vs), .auto_en(auto_en), .pattern_sel(pattern_sel),
    .pdata_rgb(pdata_rgb), .pattern_cur(pattern_cur)
  );

  always #5 pclk = ~pclk;

  task automatic model_reset();
    m_pat = 0; m_bx = 0; m_by = 0; m_cnt = 0;
    m_dx = 1; m_dy = 1; m_auto = 0;
  endtask

  task automatic move_axis(inout int pos, inout bit fwd, input int span);
    if (fwd) begin
      if (pos + BOX_STEP >= span - BOX_SIZE) begin pos = span - BOX_SIZE; fwd = 0; end
      else pos = pos + BOX_STEP;
    end else begin
      if (pos <= BOX_STEP) begin pos = 0; fwd = 1; end
      else pos = pos - BOX_STEP;
    end
  endtask

  task automatic model_tick();
    move_axis(m_bx, m_dx, H_DISP);
    move_axis(m_by, m_dy, V_DISP);
    if (!auto_en) begin
      m_pat = int'(pattern_sel); m_cnt = 0; m_auto = 0;
    end else if (!m_auto) begin
      m_auto = 1; m_cnt = 0;
      if (m_pat > 4) m_pat = 0;
    end else if (m_cnt == FPP - 1) begin
      m_cnt = 0; m_pat = (m_pat + 1) % 5;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int x, input int yraw);
    int y, g;
    y = yraw - Y_OFFSET;
    if (yraw < Y_OFFSET || y >= V_DISP || x >= H_DISP) return 24'h000000;
`ifdef PATTERN_BORDER_EN
    if (x == 0 || x == H_DISP - 1 || y == 0 || y == V_DISP - 1) return 24'hFFFFFF;
`endif
    case (m_pat)
      0: begin
        case (x / (H_DISP / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = x / 4;
        if (g > 255) g = 255;
        return {g[7:0], g[7:0], g[7:0]};
      end
      3: begin
        g = y / 4;
        if (g > 255) g = 255;
        return {8'h00, g[7:0], 8'(255 - g)};
      end
      4: return (x >= m_bx && x < m_bx + BOX_SIZE && y >= m_by && y < m_by + BOX_SIZE)
                ? 24'hFFFFFF : 24'h000040;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic do_request(input int x, input int y, output logic [23:0] got);
    @(negedge pclk);
    p_xpos = 16'(x);
    p_ypos = 16'(y);
    @(posedge pclk);
    #1;
    got = pdata_rgb;
  endtask

  task automatic frame_tick();
    @(negedge pclk);
    video_vs = 1'b0;
    @(negedge pclk);
    video_vs = 1'b1;
    model_tick();
  endtask

  task automatic apply_reset();
    @(negedge pclk);
    arst = 1'b1;
    model_reset();
    @(negedge pclk);
    arst = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    arst = 1'b1; video_vs = 1'b1; auto_en = 1'b0; pattern_sel = 3'd0;
    p_xpos = 16'd0; p_ypos = 16'd1;
    model_reset();
    do_request(0, 1, got);
    n_checks++;
    if (got !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL reset_pdata: got %06h expected 000000", got);
    end
    n_checks++;
    if (pattern_cur !== 3'd0) begin
      n_fail++; $display("[TB] FAIL reset_pattern: got %0d expected 0", pattern_cur);
    end
    @(negedge pclk);
    arst = 1'b0;
    @(posedge pclk);
    #1;
    n_checks++;
    if (pdata_rgb !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL release_first_pixel: got %06h expected FFFFFF", pdata_rgb);
    end
  endtask

  task automatic test_color_bars();
    logic [23:0] got, exp;
    int xs[11] = '{0, 160, 1279, 159, 320, 480, 640, 800, 960, 1120, 1280};
    for (int i = 0; i < 11; i++) begin
      do_request(xs[i], 1, got);
      exp = ref_pixel(xs[i], 1);
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("[TB] FAIL bars x=%0d: got %06h expected %06h", xs[i], got, exp);
      end
    end
    do_request(160, 721, got);
    n_checks++;
    if (got !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL bars_below_frame: got %06h expected 000000", got);
    end
  endtask

  task automatic test_pattern_switch();
    logic [23:0] got, exp;
    @(negedge pclk);
    pattern_sel = 3'd1;
    for (int i = 0; i < 3; i++) begin
      do_request(32, 1, got);
      n_checks++;
      if (pattern_cur !== 3'd0) begin
        n_fail++; $display("[TB] FAIL midframe_hold: got %0d expected 0", pattern_cur);
      end
    end
    frame_tick();
    n_checks++;
    if (pattern_cur !== 3'd1) begin
      n_fail++; $display("[TB] FAIL switch_after_tick: got %0d expected 1", pattern_cur);
    end
    do_request(32, 1, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL checker_32_1: got %06h expected FFFFFF", got);
    end
    do_request(32, 33, got);
    n_checks++;
    if (got !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL checker_32_33: got %06h expected 000000", got);
    end
    for (int i = 0; i < 12; i++) begin
      int x, y;
      x = $urandom_range(0, 1300); y = $urandom_range(0, 740);
      do_request(x, y, got);
      exp = ref_pixel(x, y);
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("[TB] FAIL checker_rand (%0d,%0d): got %06h expected %06h", x, y, got, exp);
      end
    end
  endtask

  task automatic test_ramp_and_range();
    logic [23:0] got;
    pattern_sel = 3'd2;
    frame_tick();
    n_checks++;
    if (pattern_cur !== 3'd2) begin
      n_fail++; $display("[TB] FAIL ramp_select: got %0d expected 2", pattern_cur);
    end
    do_request(400, 1, got);
    n_checks++;
    if (got !== 24'h646464) begin
      n_fail++; $display("[TB] FAIL ramp_400: got %06h expected 646464", got);
    end
    do_request(1279, 1, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL ramp_1279: got %06h expected FFFFFF", got);
    end
    do_request(400, 0, got);
    n_checks++;
    if (got !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL range_ypos0: got %06h expected 000000", got);
    end
    do_request(1280, 5, got);
    n_checks++;
    if (got !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL range_xpos1280: got %06h expected 000000", got);
    end
  endtask

  task automatic test_gradient();
    logic [23:0] got, exp;
    pattern_sel = 3'd3;
    frame_tick();
    do_request(5, 401, got);
    n_checks++;
    if (got !== 24'h00649B) begin
      n_fail++; $display("[TB] FAIL gradient_y400: got %06h expected 00649B", got);
    end
    for (int i = 0; i < 12; i++) begin
      int x, y;
      x = $urandom_range(0, 1300); y = $urandom_range(0, 740);
      do_request(x, y, got);
      exp = ref_pixel(x, y);
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("[TB] FAIL gradient_rand (%0d,%0d): got %06h expected %06h", x, y, got, exp);
      end
    end
  endtask

  task automatic test_box();
    logic [23:0] got, exp;
    apply_reset();
    auto_en = 1'b0;
    pattern_sel = 3'd4;
    for (int i = 0; i < 3; i++) frame_tick();
    do_request(12, 13, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL box_12_13: got %06h expected FFFFFF", got);
    end
    do_request(11, 13, got);
    n_checks++;
    if (got !== 24'h000040) begin
      n_fail++; $display("[TB] FAIL box_11_13: got %06h expected 000040", got);
    end
    for (int i = 0; i < 301; i++) frame_tick();
    do_request(1216, m_by + Y_OFFSET, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL box_clamp_edge: got %06h expected FFFFFF", got);
    end
    do_request(1215, m_by + Y_OFFSET, got);
    n_checks++;
    if (got !== 24'h000040) begin
      n_fail++; $display("[TB] FAIL box_clamp_left: got %06h expected 000040", got);
    end
    frame_tick();
    do_request(1212, m_by + Y_OFFSET, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL box_reverse_edge: got %06h expected FFFFFF", got);
    end
    do_request(1276, m_by + Y_OFFSET, got);
    n_checks++;
    if (got !== 24'h000040) begin
      n_fail++; $display("[TB] FAIL box_reverse_right: got %06h expected 000040", got);
    end
    for (int i = 0; i < 12; i++) begin
      int x, y;
      x = m_bx + $urandom_range(0, 80) - 8; y = m_by + $urandom_range(0, 80) - 8;
      do_request(x, y, got);
      exp = ref_pixel(x, y);
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("[TB] FAIL box_rand (%0d,%0d): got %06h expected %06h", x, y, got, exp);
      end
    end
  endtask

  task automatic test_auto_mode();
    logic [23:0] got, exp;
    int exp_seq[7] = '{4, 4, 4, 0, 0, 0, 1};
    pattern_sel = 3'd4;
    frame_tick();
    auto_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      frame_tick();
      pattern_sel = 3'($urandom_range(0, 7));
      n_checks++;
      if (pattern_cur !== 3'(exp_seq[i])) begin
        n_fail++; $display("[TB] FAIL auto_seq[%0d]: got %0d expected %0d", i, pattern_cur, exp_seq[i]);
      end
      do_request($urandom_range(0, 1279), $urandom_range(1, 720), got);
      exp = ref_pixel(int'(p_xpos), int'(p_ypos));
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("[TB] FAIL auto_pixel[%0d]: got %06h expected %06h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] got;
    do_request(32, 1, got);
    n_checks++;
    if (got !== ref_pixel(32, 1)) begin
      n_fail++; $display("[TB] FAIL pre_reset_pixel: got %06h expected %06h", got, ref_pixel(32, 1));
    end
    #2;
    arst = 1'b1;
    #1;
    n_checks++;
    if (pdata_rgb !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL async_reset_pdata: got %06h expected 000000", pdata_rgb);
    end
    n_checks++;
    if (pattern_cur !== 3'd0) begin
      n_fail++; $display("[TB] FAIL async_reset_pattern: got %0d expected 0", pattern_cur);
    end
    model_reset();
    auto_en = 1'b0;
    pattern_sel = 3'd4;
    @(negedge pclk);
    arst = 1'b0;
    do_request(0, 1, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL post_reset_bars: got %06h expected FFFFFF", got);
    end
    frame_tick();
    do_request(4, 5, got);
    n_checks++;
    if (got !== 24'hFFFFFF) begin
      n_fail++; $display("[TB] FAIL box_from_origin: got %06h expected FFFFFF", got);
    end
    do_request(3, 5, got);
    n_checks++;
    if (got !== 24'h000040) begin
      n_fail++; $display("[TB] FAIL box_left_of_origin: got %06h expected 000040", got);
    end
    do_request(68, 5, got);
    n_checks++;
    if (got !== 24'h000040) begin
      n_fail++; $display("[TB] FAIL box_right_of_origin: got %06h expected 000040", got);
    end
  endtask

  task automatic test_border();
    logic [23:0] got, exp;
    int xs[5] = '{0, 1279, 1, 640, 1279};
    int ys[5] = '{1, 720, 2, 360, 1};
    pattern_sel = 3'd5;
    frame_tick();
    n_checks++;
    if (pattern_cur !== 3'd5) begin
      n_fail++; $display("[TB] FAIL border_select: got %0d expected 5", pattern_cur);
    end
    for (int i = 0; i < 5; i++) begin
      do_request(xs[i], ys[i], got);
      exp = ref_pixel(xs[i], ys[i]);
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("[TB] FAIL border (%0d,%0d): got %06h expected %06h", xs[i], ys[i], got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_color_bars();
    test_pattern_switch();
    test_ramp_and_range();
    test_gradient();
    test_box();
    test_auto_mode();
    test_async_reset();
    test_border();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
